// File: rtl/audio_mixer_tdm.sv
// Time-multiplexed stereo audio mixer: one MAC per channel per cycle, master gain, saturation.
// Optional peak meters on the output handshake when AUDIO_MIXER_PEAK_EN is defined.
module audio_mixer_tdm #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 16,
    parameter int VOL_W    = 8,
    parameter int VOL_FRAC = 7
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         sample_tick,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_sample,
    input  logic [NUM_CH*VOL_W-1:0]      ch_volume,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH-1:0]            ch_mono,
    input  logic [NUM_CH-1:0]            ch_right,
    input  logic [VOL_W-1:0]             master_volume,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [SAMPLE_W-1:0]          m_left,
    output logic [SAMPLE_W-1:0]          m_right,
`ifdef AUDIO_MIXER_PEAK_EN
    input  logic                         peak_clr,
    output logic [SAMPLE_W-2:0]          peak_left,
    output logic [SAMPLE_W-2:0]          peak_right,
`endif
    output logic                         busy,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam int ACC_W  = SAMPLE_W + VOL_W + $clog2(NUM_CH) + 2;
    localparam int PROD_W = SAMPLE_W + VOL_W + 1;
    localparam int SCL_W  = ACC_W + VOL_W + 1;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic signed [SCL_W-1:0] SAT_MAX = {{(SCL_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SCL_W-1:0] SAT_MIN = {{(SCL_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCALE, S_OUTPUT} state_t;

    state_t                      r_state;
    logic                        r_busy;
    logic                        r_valid;
    logic                        r_overrun;
    logic [SAMPLE_W-1:0]         r_left;
    logic [SAMPLE_W-1:0]         r_right;
    logic [IDX_W-1:0]            r_idx;
    logic signed [ACC_W-1:0]     r_accl;
    logic signed [ACC_W-1:0]     r_accr;
    logic signed [ACC_W-1:0]     r_p;
    logic                        r_pv;
    logic                        r_pl;
    logic                        r_pr;

    logic signed [SAMPLE_W-1:0]  r_samp [NUM_CH];
    logic [VOL_W-1:0]            r_vol  [NUM_CH];
    logic [NUM_CH-1:0]           r_en;
    logic [NUM_CH-1:0]           r_mono;
    logic [NUM_CH-1:0]           r_rgt;
    logic [VOL_W-1:0]            r_master;

    logic signed [SAMPLE_W-1:0]  w_samp;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [PROD_W-1:0]    w_pshift;
    logic signed [ACC_W-1:0]     w_pext;
    logic signed [SCL_W-1:0]     w_scl_l;
    logic signed [SCL_W-1:0]     w_scl_r;
    logic signed [SCL_W-1:0]     w_scl_l_sh;
    logic signed [SCL_W-1:0]     w_scl_r_sh;
    logic                        w_hs;
    logic                        w_take;
    logic                        w_drop;

    function automatic logic [SAMPLE_W-1:0] sat(input logic signed [SCL_W-1:0] v);
        if (v > SAT_MAX)
            sat = SAT_MAX[SAMPLE_W-1:0];
        else if (v < SAT_MIN)
            sat = SAT_MIN[SAMPLE_W-1:0];
        else
            sat = v[SAMPLE_W-1:0];
    endfunction

    assign w_samp     = r_samp[r_idx];
    assign w_prod     = w_samp * $signed({1'b0, r_vol[r_idx]});
    assign w_pshift   = w_prod >>> VOL_FRAC;
    assign w_pext     = {{(ACC_W-PROD_W){w_pshift[PROD_W-1]}}, w_pshift};
    assign w_scl_l    = r_accl * $signed({1'b0, r_master});
    assign w_scl_r    = r_accr * $signed({1'b0, r_master});
    assign w_scl_l_sh = w_scl_l >>> VOL_FRAC;
    assign w_scl_r_sh = w_scl_r >>> VOL_FRAC;

    assign w_hs   = (r_state == S_OUTPUT) && m_ready;
    assign w_take = sample_tick && ((r_state == S_IDLE) || w_hs);
    assign w_drop = sample_tick && (r_state != S_IDLE) && !w_hs;

    // Products are registered one cycle before accumulation; SCALE waits for the
    // last product to land, which gives the fixed NUM_CH+2 latency.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_left    <= '0;
            r_right   <= '0;
            r_idx     <= '0;
            r_accl    <= '0;
            r_accr    <= '0;
            r_p       <= '0;
            r_pv      <= 1'b0;
            r_pl      <= 1'b0;
            r_pr      <= 1'b0;
            r_en      <= '0;
            r_mono    <= '0;
            r_rgt     <= '0;
            r_master  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_samp[i] <= '0;
                r_vol[i]  <= '0;
            end
        end else begin
            r_pv <= 1'b0;
            if (r_pv) begin
                if (r_pl) r_accl <= r_accl + r_p;
                if (r_pr) r_accr <= r_accr + r_p;
            end

            if (w_drop)
                r_overrun <= 1'b1;
            else if (overrun_clr)
                r_overrun <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (sample_tick) begin
                        r_state <= S_ACCUM;
                        r_busy  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_pv  <= 1'b1;
                    r_p   <= w_pext;
                    r_pl  <= r_en[r_idx] && (r_mono[r_idx] || !r_rgt[r_idx]);
                    r_pr  <= r_en[r_idx] && (r_mono[r_idx] ||  r_rgt[r_idx]);
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(NUM_CH - 1))
                        r_state <= S_SCALE;
                end
                S_SCALE: begin
                    if (!r_pv) begin
                        r_left  <= sat(w_scl_l_sh);
                        r_right <= sat(w_scl_r_sh);
                        r_valid <= 1'b1;
                        r_state <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (m_ready) begin
                        r_valid <= 1'b0;
                        if (sample_tick) begin
                            r_state <= S_ACCUM;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_take) begin
                r_accl   <= '0;
                r_accr   <= '0;
                r_idx    <= '0;
                r_en     <= ch_enable;
                r_mono   <= ch_mono;
                r_rgt    <= ch_right;
                r_master <= master_volume;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    r_samp[i] <= ch_sample[i*SAMPLE_W +: SAMPLE_W];
                    r_vol[i]  <= ch_volume[i*VOL_W +: VOL_W];
                end
            end
        end
    end

    assign m_valid = r_valid;
    assign m_left  = r_left;
    assign m_right = r_right;
    assign busy    = r_busy;
    assign overrun = r_overrun;

`ifdef AUDIO_MIXER_PEAK_EN
    logic [SAMPLE_W-2:0] r_peak_l;
    logic [SAMPLE_W-2:0] r_peak_r;
    logic [SAMPLE_W-2:0] w_mag_l;
    logic [SAMPLE_W-2:0] w_mag_r;

    // Most-negative sample has no positive twin; clamp its magnitude to full scale.
    function automatic logic [SAMPLE_W-2:0] mag(input logic [SAMPLE_W-1:0] v);
        logic [SAMPLE_W-1:0] n;
        n = -v;
        if (!v[SAMPLE_W-1])
            mag = v[SAMPLE_W-2:0];
        else if (v[SAMPLE_W-2:0] == '0)
            mag = '1;
        else
            mag = n[SAMPLE_W-2:0];
    endfunction

    assign w_mag_l = mag(r_left);
    assign w_mag_r = mag(r_right);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
        end else if (peak_clr) begin
            r_peak_l <= w_hs ? w_mag_l : '0;
            r_peak_r <= w_hs ? w_mag_r : '0;
        end else if (w_hs) begin
            if (w_mag_l > r_peak_l) r_peak_l <= w_mag_l;
            if (w_mag_r > r_peak_r) r_peak_r <= w_mag_r;
        end
    end

    assign peak_left  = r_peak_l;
    assign peak_right = r_peak_r;
`endif

endmodule

// File: tb/tb_audio_mixer_tdm.sv
// Directed self-checking bench for audio_mixer_tdm (default parameters).
// Exercises peak meters too when AUDIO_MIXER_PEAK_EN is defined.
module tb_audio_mixer_tdm;

    logic         aclk;
    logic         aresetn;
    logic         sample_tick;
    logic [127:0] ch_sample;
    logic [63:0]  ch_volume;
    logic [7:0]   ch_enable;
    logic [7:0]   ch_mono;
    logic [7:0]   ch_right;
    logic [7:0]   master_volume;
    logic         m_valid;
    logic         m_ready;
    logic [15:0]  m_left;
    logic [15:0]  m_right;
    logic         busy;
    logic         overrun;
    logic         overrun_clr;
`ifdef AUDIO_MIXER_PEAK_EN
    logic         peak_clr;
    logic [14:0]  peak_left;
    logic [14:0]  peak_right;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    audio_mixer_tdm #(
        .NUM_CH(8), .SAMPLE_W(16), .VOL_W(8), .VOL_FRAC(7)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .sample_tick(sample_tick),
        .ch_sample(ch_sample),
        .ch_volume(ch_volume),
        .ch_enable(ch_enable),
        .ch_mono(ch_mono),
        .ch_right(ch_right),
        .master_volume(master_volume),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_left(m_left),
        .m_right(m_right),
`ifdef AUDIO_MIXER_PEAK_EN
        .peak_clr(peak_clr),
        .peak_left(peak_left),
        .peak_right(peak_right),
`endif
        .busy(busy),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_ch(input int unsigned i, input int s, input int v,
                          input logic en, input logic mono, input logic rt);
        ch_sample[i*16 +: 16] = 16'(s);
        ch_volume[i*8 +: 8]   = 8'(v);
        ch_enable[i]          = en;
        ch_mono[i]            = mono;
        ch_right[i]           = rt;
    endtask

    // Disabled channels carry a loud sample so an ignored enable shows up.
    task automatic clear_all();
        for (int unsigned i = 0; i < 8; i++)
            set_ch(i, 12345, 128, 1'b0, 1'b1, 1'b0);
        master_volume = 8'd128;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!m_valid && n < 40) begin
            cyc();
            sample_tick = 1'b0;
            n++;
        end
    endtask

    // Tick in IDLE with m_ready=1; n includes the tick-sampling edge.
    task automatic run_frame(input string tag, input int exp_l, input int exp_r);
        int n;
        m_ready     = 1'b1;
        sample_tick = 1'b1;
        wait_valid(n);
        check({tag, "_latency"}, n - 1, 10);
        check({tag, "_left"},  $signed(m_left),  exp_l);
        check({tag, "_right"}, $signed(m_right), exp_r);
        cyc();
        check({tag, "_valid_drop"}, int'(m_valid), 0);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        aresetn       = 1'b0;
        sample_tick   = 1'b0;
        m_ready       = 1'b1;
        overrun_clr   = 1'b0;
        ch_sample     = '0;
        ch_volume     = '0;
        ch_enable     = '0;
        ch_mono       = '0;
        ch_right      = '0;
        master_volume = '0;
`ifdef AUDIO_MIXER_PEAK_EN
        peak_clr      = 1'b0;
`endif
        clear_all();
        repeat (3) cyc();
        check("rst_valid",   int'(m_valid), 0);
        check("rst_left",    int'(m_left), 0);
        check("rst_right",   int'(m_right), 0);
        check("rst_busy",    int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
`ifdef AUDIO_MIXER_PEAK_EN
        check("rst_peak_l", int'(peak_left), 0);
`endif
        aresetn = 1'b1;
        cyc();

        // Single mono channel at unity gain.
        clear_all();
        set_ch(0, 1000, 128, 1'b1, 1'b1, 1'b0);
        run_frame("unity", 1000, 1000);

        // Saturation both ways.
        for (int unsigned i = 0; i < 8; i++) set_ch(i, 16000, 128, 1'b1, 1'b1, 1'b0);
        run_frame("sat_pos", 32767, 32767);
        for (int unsigned i = 0; i < 8; i++) set_ch(i, -16000, 128, 1'b1, 1'b1, 1'b0);
        run_frame("sat_neg", -32768, -32768);

        // Floor rounding on half volume, then routing.
        clear_all();
        set_ch(0, -3, 64, 1'b1, 1'b1, 1'b0);
        run_frame("floor", -2, -2);
        set_ch(1, 500, 128, 1'b1, 1'b0, 1'b0);
        set_ch(2, 700, 128, 1'b1, 1'b0, 1'b1);
        run_frame("route", 498, 698);

        // Master volume at half: 1000 -> 500, and -3 -> floor(-1.5) = -2.
        clear_all();
        master_volume = 8'd64;
        set_ch(0, 1000, 128, 1'b1, 1'b1, 1'b0);
        run_frame("master_half", 500, 500);
        set_ch(0, -3, 128, 1'b1, 1'b1, 1'b0);
        run_frame("master_floor", -2, -2);

        // Back-pressure: frame held, dropped ticks set overrun, set beats clear.
        clear_all();
        set_ch(0, 1000, 128, 1'b1, 1'b1, 1'b0);
        m_ready     = 1'b0;
        sample_tick = 1'b1;
        wait_valid(n);
        check("bp_latency", n - 1, 10);
        repeat (3) cyc();
        check("bp_hold_valid", int'(m_valid), 1);
        check("bp_overrun0",   int'(overrun), 0);
        set_ch(0, 7000, 128, 1'b1, 1'b1, 1'b0);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        check("bp_overrun_set", int'(overrun), 1);
        check("bp_hold_left",   $signed(m_left), 1000);
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        cyc();
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        check("bp_set_wins", int'(overrun), 1);
        repeat (8) cyc();
        check("bp_hold_right", $signed(m_right), 1000);
        check("bp_hold_busy",  int'(busy), 1);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        check("bp_clear", int'(overrun), 0);
        m_ready = 1'b1;
        cyc();
        check("bp_release", int'(m_valid), 0);

        // Input change right after the snapshot edge must not leak in.
        clear_all();
        set_ch(0, 1000, 128, 1'b1, 1'b1, 1'b0);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        set_ch(0, 5000, 128, 1'b1, 1'b1, 1'b0);
        wait_valid(n);
        check("snap_latency", n, 10);
        check("snap_left", $signed(m_left), 1000);
        cyc();

        // Tick coincident with handshake starts the next frame directly.
        set_ch(0, 1000, 128, 1'b1, 1'b1, 1'b0);
        m_ready     = 1'b0;
        sample_tick = 1'b1;
        wait_valid(n);
        check("coin_first", $signed(m_left), 1000);
        set_ch(0, 2000, 128, 1'b1, 1'b1, 1'b0);
        m_ready     = 1'b1;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        check("coin_valid_drop", int'(m_valid), 0);
        check("coin_busy",       int'(busy), 1);
        check("coin_no_overrun", int'(overrun), 0);
        wait_valid(n);
        check("coin_latency", n, 10);
        check("coin_left", $signed(m_left), 2000);
        cyc();

        // Async reset during ACCUM.
        clear_all();
        set_ch(0, 1000, 128, 1'b1, 1'b1, 1'b0);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        repeat (3) cyc();
        check("rstacc_busy_pre", int'(busy), 1);
        aresetn = 1'b0;
        #1;
        check("rstacc_busy",  int'(busy), 0);
        check("rstacc_valid", int'(m_valid), 0);
        cyc();
        aresetn = 1'b1;
        cyc();
        run_frame("after_rst", 1000, 1000);

        // Async reset while a frame is held in OUTPUT with overrun set.
        m_ready     = 1'b0;
        sample_tick = 1'b1;
        wait_valid(n);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        check("rstout_overrun_pre", int'(overrun), 1);
        aresetn = 1'b0;
        #1;
        check("rstout_valid",   int'(m_valid), 0);
        check("rstout_left",    int'(m_left), 0);
        check("rstout_overrun", int'(overrun), 0);
        cyc();
        aresetn = 1'b1;
        m_ready = 1'b1;
        cyc();

`ifdef AUDIO_MIXER_PEAK_EN
        clear_all();
        set_ch(0, 1000, 128, 1'b1, 1'b1, 1'b0);
        run_frame("pk1", 1000, 1000);
        check("peak_l_1000", int'(peak_left), 1000);
        set_ch(0, -2000, 128, 1'b1, 1'b1, 1'b0);
        run_frame("pk2", -2000, -2000);
        check("peak_l_2000", int'(peak_left), 2000);
        check("peak_r_2000", int'(peak_right), 2000);
        set_ch(0, 1000, 128, 1'b1, 1'b1, 1'b0);
        run_frame("pk3", 1000, 1000);
        check("peak_l_keep", int'(peak_left), 2000);
        for (int unsigned i = 0; i < 8; i++) set_ch(i, -16000, 128, 1'b1, 1'b1, 1'b0);
        run_frame("pk4", -32768, -32768);
        check("peak_l_minneg", int'(peak_left), 32767);
        peak_clr = 1'b1;
        cyc();
        peak_clr = 1'b0;
        check("peak_l_clr", int'(peak_left), 0);
        check("peak_r_clr", int'(peak_right), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
